// File: rtl/wavelet_pkg.sv
// Shared constants and window-FSM encoding for the wavelet decomposition path.
// The FIR layer imports the same sample width and tap geometry.
package wavelet_pkg;

  localparam int ADC_WIDTH     = 16;
  localparam int NUM_TAPS      = 179;
  localparam int NUM_PAIRS     = (NUM_TAPS - 1) / 2;
  localparam int FILL_CNT_W    = 8;
  localparam int DECIM_DEFAULT = 2;

  typedef enum logic {
    WIN_FILL = 1'b0,
    WIN_RUN  = 1'b1
  } win_state_e;

endpackage

// File: rtl/fir_window_ctrl.sv
// Fill/decimation control for the FIR sample window: tracks how many samples
// the delay line holds and when a decimated window is ready for the FIR.
module fir_window_ctrl #(
  parameter int NUM_TAPS = wavelet_pkg::NUM_TAPS,
  parameter int DECIM    = wavelet_pkg::DECIM_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic accept_i,
  input  logic flush_i,
  output logic shift_en_o,
  output logic valid_out_o,
  output logic primed_o
);
  import wavelet_pkg::*;

  localparam int                    PHASE_W    = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam logic [PHASE_W-1:0]    PHASE_LAST = PHASE_W'(DECIM - 1);
  localparam logic [FILL_CNT_W-1:0] FILL_LAST  = FILL_CNT_W'(NUM_TAPS - 1);

  win_state_e            state_q;
  logic [FILL_CNT_W-1:0] fill_cnt_q;
  logic [PHASE_W-1:0]    phase_q;
  logic [PHASE_W-1:0]    phase_d;
  logic                  valid_q;
  logic                  primed_q;

  // A flush in the same cycle as a strobe drops the sample.
  assign shift_en_o  = accept_i & ~flush_i;
  assign valid_out_o = valid_q;
  assign primed_o    = primed_q;

  // NOTE: default assigned first so every path drives phase_d; no latch.
  always_comb begin
    phase_d = phase_q + 1'b1;
    if (phase_q == PHASE_LAST) begin
      phase_d = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so all
  // registers update together from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= WIN_FILL;
      fill_cnt_q <= '0;
      phase_q    <= '0;
      valid_q    <= 1'b0;
      primed_q   <= 1'b0;
    end else if (flush_i) begin
      state_q    <= WIN_FILL;
      fill_cnt_q <= '0;
      phase_q    <= '0;
      valid_q    <= 1'b0;
      primed_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (accept_i) begin
        case (state_q)
          WIN_FILL: begin
            fill_cnt_q <= fill_cnt_q + 1'b1;
            if (fill_cnt_q == FILL_LAST) begin
              state_q  <= WIN_RUN;
              primed_q <= 1'b1;
              valid_q  <= 1'b1;
              phase_q  <= '0;
            end
          end
          WIN_RUN: begin
            // Fill count stays frozen; only the decimation phase advances.
            phase_q <= phase_d;
            valid_q <= (phase_d == '0);
          end
          default: begin
            state_q <= WIN_FILL;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/fir_sample_window.sv
// Per-channel window builder ahead of the symmetric FIR: a shift-register delay
// line whose taps are presented folded as pair A/B vectors plus the centre tap.
module fir_sample_window #(
  parameter int ADC_WIDTH = wavelet_pkg::ADC_WIDTH,
  parameter int NUM_TAPS  = wavelet_pkg::NUM_TAPS,
  parameter int NUM_PAIRS = wavelet_pkg::NUM_PAIRS,
  parameter int DECIM     = wavelet_pkg::DECIM_DEFAULT
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic signed [ADC_WIDTH-1:0]    adc_data,
  input  logic                           adc_valid,
  input  logic                           flush,
  output logic [NUM_PAIRS*ADC_WIDTH-1:0] samples_a,
  output logic [NUM_PAIRS*ADC_WIDTH-1:0] samples_b,
  output logic [ADC_WIDTH-1:0]           sample_center,
  output logic                           valid_out,
  output logic                           primed
);
  import wavelet_pkg::*;

  logic                 shift_en;
  logic [ADC_WIDTH-1:0] win_q [NUM_TAPS];

  fir_window_ctrl #(
    .NUM_TAPS (NUM_TAPS),
    .DECIM    (DECIM)
  ) u_ctrl (
    .clk         (clk),
    .rst_n       (rst_n),
    .accept_i    (adc_valid),
    .flush_i     (flush),
    .shift_en_o  (shift_en),
    .valid_out_o (valid_out),
    .primed_o    (primed)
  );

  // NOTE: the delay line is reset because its taps drive the outputs directly
  // and must read zero immediately on reset; it cannot map to a RAM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_TAPS; k++) begin
        win_q[k] <= '0;
      end
    end else if (flush) begin
      for (int k = 0; k < NUM_TAPS; k++) begin
        win_q[k] <= '0;
      end
    end else if (shift_en) begin
      win_q[0] <= adc_data;
      for (int k = 1; k < NUM_TAPS; k++) begin
        win_q[k] <= win_q[k-1];
      end
    end
  end

  // Pair j folds the j-th newest sample with the j-th oldest.
  for (genvar j = 0; j < NUM_PAIRS; j++) begin : g_fold
    assign samples_a[j*ADC_WIDTH +: ADC_WIDTH] = win_q[j];
    assign samples_b[j*ADC_WIDTH +: ADC_WIDTH] = win_q[NUM_TAPS-1-j];
  end

  assign sample_center = win_q[NUM_PAIRS];

endmodule

// File: doc/fir_sample_window.md
# fir_sample_window

Upstream window builder for the 179-tap symmetric FIR layer. It accepts one ADC sample per `adc_valid` into a 179-deep delay line and maintains fill and decimation control. On each output phase it presents the folded window to the FIR as flattened `samples_a` / `samples_b` / `sample_center` with a one-cycle `valid_out` pulse. One instance per channel, placed directly before the FIR layer in the wavelet decomposition path.

## Interface
- `ADC_WIDTH`, 16: sample width, signed Q16.0.
- `NUM_TAPS`, 179: delay-line depth; must be odd.
- `NUM_PAIRS`, 89: (NUM_TAPS-1)/2 symmetric pairs.
- `DECIM`, 2: output decimation factor; legal values 1 or 2.
- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `adc_data` in ADC_WIDTH: signed input sample.
- `adc_valid` in 1: sample strobe; one sample accepted per high cycle.
- `flush` in 1: synchronous clear of window and control state.
- `samples_a` out NUM_PAIRS*ADC_WIDTH: pair j at bits [j*16 +: 16] = d[j].
- `samples_b` out NUM_PAIRS*ADC_WIDTH: pair j = d[NUM_TAPS-1-j].
- `sample_center` out ADC_WIDTH: d[NUM_PAIRS].
- `valid_out` out 1: one-cycle pulse; window is valid for the FIR.
- `primed` out 1: level; window has held NUM_TAPS samples since reset or flush.

## Operation
- Delay line d[0..178]: d[0] is the newest sample, d[178] the oldest. Contents are all zero after reset or flush.
- Accept (`adc_valid`=1, `flush`=0): d[0]←adc_data and d[k]←d[k-1]. No accept means no shift, and the outputs hold.
- Outputs are direct register taps of the delay line. There is no arithmetic and no width change.
- FSM states:
  - FILL: fill counter (8 bits) increments per accept. The accept that brings the count to NUM_TAPS moves the FSM to RUN and sets `primed`.
  - RUN: the counter is frozen. The phase counter (0..DECIM-1) wraps per accept.
- `valid_out` pulses for:
  - the accept that completes the fill;
  - every subsequent accept where phase returns to 0.
  - With DECIM=2 this gives samples 179, 181, 183, …; with DECIM=1 it is every accept from 179 on.
- `flush`:
  - zeroes d[], the fill count and the phase;
  - sets the FSM to FILL and clears `primed` and `valid_out`.
  - If `flush` and `adc_valid` are high in the same cycle, flush wins and the sample is dropped.
- No backpressure: the downstream FIR is fully pipelined and accepts every `valid_out`.

## Timing
- Latency: `valid_out` and the updated window appear on the clock edge that registers the accepted sample, i.e. the cycle after `adc_valid` is sampled high.
- Throughput: one sample per clock sustained. Gaps in `adc_valid` of any length are legal and do not alter the sample-count sequence.
- The window is stable from a `valid_out` until the next accept.
- Reset values, applied asynchronously on `rst_n` low:
  - all of `samples_a`, `samples_b` and `sample_center` are 0;
  - `valid_out`=0, `primed`=0;
  - FSM=FILL, counters=0.
- Release of `rst_n` is synchronous to `clk`. The first accept can occur on the first edge after release.
- If reset or flush occurs mid-stream, no pre-clear sample ever reaches the outputs after the clear.

## Structure
- Shared package `wavelet_pkg` holds:
  - ADC_WIDTH, NUM_TAPS and NUM_PAIRS constants, shared with the FIR layer;
  - the window FSM state encoding (FILL, RUN).
- Sub-module `fir_window_ctrl` contains the FSM, fill counter, phase counter, and `valid_out`/`primed` generation. It takes `accept`/`flush` in and drives a shift-enable out.
- The top level holds the delay line and output flattening.

## Test plan
1. Reset, DECIM=2, feed values 1..179 contiguously. Expect exactly one `valid_out`, on sample 179, with:
   - a0=179, b0=1, center=90;
   - a88=91, b88=89;
   - `primed` rising on the same edge.
2. Continue with 180..183. Expect `valid_out` only after 181 (a0=181, b0=3, center=92) and after 183 (a0=183, b0=5, center=94).
3. Same stream as 1–2 with random 0–5-cycle `adc_valid` gaps. Expect identical window values and pulse count, and outputs held during gaps.
4. Feed 100 samples, assert `flush`, then feed 179 samples of value 7. Expect:
   - no `valid_out` before the 179th post-flush sample;
   - all taps equal 7 at that pulse.
5. Assert `rst_n` low asynchronously mid-RUN. Expect outputs, `valid_out` and `primed` to be 0 before the next clock edge, and refill to require 179 new samples.
6. Set DECIM=1 with `flush`+`adc_valid` in the same cycle, value 99. Expect 99 to be dropped and, after priming, `valid_out` on every accept.
